// File: rtl/lsu.sv
// rtl/lsu.sv - registered, handshaked load/store unit with sub-word access and misalignment reject
module lsu #(
    parameter int W     = 32,
    parameter int OFF_W = $clog2(W/8)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic           req_write,
    input  logic [1:0]     req_size,
    input  logic           req_signed,
    input  logic [W-1:0]   req_addr,
    input  logic [W-1:0]   req_wdata,
    output logic           stall,
    output logic           resp_valid,
    output logic [W-1:0]   resp_rdata,
    output logic           exc_misalign,
    output logic [W-1:0]   exc_addr,
    output logic           bus_req,
    output logic           bus_we,
    output logic [W-1:0]   bus_addr,
    output logic [W/8-1:0] bus_be,
    output logic [W-1:0]   bus_wdata,
    input  logic           bus_ack,
    input  logic [W-1:0]   bus_rdata
);
    localparam int NB = W/8;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next;

    logic             w_legal, w_accept, w_reject, w_done;
    logic [OFF_W-1:0] w_off, w_amask;
    logic [3:0]       w_n;
    logic [NB-1:0]    w_span, w_be;
    logic [W-1:0]     w_shifted, w_load;

    logic             r_resp_valid, r_exc, r_bus_we, r_signed;
    logic [W-1:0]     r_resp_rdata, r_exc_addr, r_bus_addr, r_bus_wdata;
    logic [NB-1:0]    r_bus_be;
    logic [OFF_W-1:0] r_off;
    logic [1:0]       r_size;

    // Request decode: alignment mask has bit j set for every address bit that must be zero.
    always_comb begin
        w_off   = req_addr[OFF_W-1:0];
        w_n     = 4'd1 << req_size;
        w_amask = '0;
        for (int j = 0; j < OFF_W; j++) begin
            w_amask[j] = (2'(j) < req_size);
        end
        w_legal = ({1'b0, req_size} <= MAX_SIZE) && ((w_off & w_amask) == '0);
        w_span  = '0;
        for (int i = 0; i < NB; i++) begin
            w_span[i] = (4'(i) < w_n);
        end
        w_be = w_span << w_off;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Stall drops in the response cycle so the load retires even if the next op is accepted.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_done   = 1'b0;
        stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        w_accept = 1'b1;
                        w_next   = BUSY;
                        stall    = !r_resp_valid;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ack) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_shifted = bus_rdata >> {r_off, 3'b000};
        case (r_size)
            2'd0:    w_load = r_signed ? W'($signed(w_shifted[7:0]))  : W'(w_shifted[7:0]);
            2'd1:    w_load = r_signed ? W'($signed(w_shifted[15:0])) : W'(w_shifted[15:0]);
            2'd2:    w_load = r_signed ? W'($signed(w_shifted[31:0])) : W'(w_shifted[31:0]);
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_exc        <= 1'b0;
            r_exc_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
        end else begin
            r_resp_valid <= w_done;
            r_exc        <= w_reject;
            if (w_reject) r_exc_addr <= req_addr;
            if (w_accept) begin
                r_bus_we    <= req_write;
                r_bus_addr  <= {req_addr[W-1:OFF_W], OFF_W'(0)};
                r_bus_be    <= w_be;
                r_bus_wdata <= req_write ? (req_wdata << {w_off, 3'b000}) : '0;
                r_off       <= w_off;
                r_size      <= req_size;
                r_signed    <= req_signed;
            end
            if (w_done) r_resp_rdata <= r_bus_we ? '0 : w_load;
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign exc_misalign = r_exc;
    assign exc_addr     = r_exc_addr;
    assign bus_req      = (r_state == BUSY);
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_bus_be;
    assign bus_wdata    = r_bus_wdata;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu at W=32 and W=64
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst, sel, req_valid, req_write, req_signed, bus_ack;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, bus_rdata;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    logic        s32, rv32, e32, br32, we32;
    logic [31:0] rd32, ea32, ba32, bw32;
    logic [3:0]  be32;
    logic        s64, rv64, e64, br64, we64;
    logic [63:0] rd64, ea64, ba64, bw64;
    logic [7:0]  be64;

    lsu #(.W(32)) u_lsu32 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .stall(s32), .resp_valid(rv32), .resp_rdata(rd32),
        .exc_misalign(e32), .exc_addr(ea32), .bus_req(br32), .bus_we(we32),
        .bus_addr(ba32), .bus_be(be32), .bus_wdata(bw32), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata[31:0])
    );

    lsu #(.W(64)) u_lsu64 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(s64), .resp_valid(rv64), .resp_rdata(rd64),
        .exc_misalign(e64), .exc_addr(ea64), .bus_req(br64), .bus_we(we64),
        .bus_addr(ba64), .bus_be(be64), .bus_wdata(bw64), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    logic        m_stall, m_rv, m_exc, m_breq, m_we;
    logic [63:0] m_rd, m_ea, m_ba, m_bw, m_be;
    assign m_stall = sel ? s64  : s32;
    assign m_rv    = sel ? rv64 : rv32;
    assign m_exc   = sel ? e64  : e32;
    assign m_breq  = sel ? br64 : br32;
    assign m_we    = sel ? we64 : we32;
    assign m_rd    = sel ? rd64 : {32'b0, rd32};
    assign m_ea    = sel ? ea64 : {32'b0, ea32};
    assign m_ba    = sel ? ba64 : {32'b0, ba32};
    assign m_bw    = sel ? bw64 : {32'b0, bw32};
    assign m_be    = sel ? {56'b0, be64} : {60'b0, be32};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int k, input logic [63:0] e_ba, input logic [63:0] e_be,
                       input logic [63:0] e_bw, input logic [63:0] e_resp);
        issue(wr, sz, sg, addr, wd);
        check({tag, ".stall_accept"}, m_stall, 1);
        step();
        req_valid = 1'b0;
        #1;
        for (int c = 1; c <= k; c++) begin
            check({tag, ".bus_req"}, m_breq, 1);
            check({tag, ".stall_busy"}, m_stall, 1);
            check({tag, ".bus_addr"}, m_ba, e_ba);
            check({tag, ".bus_be"}, m_be, e_be);
            check({tag, ".bus_we"}, m_we, wr);
            check({tag, ".bus_wdata"}, m_bw, e_bw);
            check({tag, ".no_resp"}, m_rv, 0);
            if (c == k) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            step();
        end
        bus_ack = 1'b0;
        #1;
        check({tag, ".resp_valid"}, m_rv, 1);
        check({tag, ".resp_rdata"}, m_rd, e_resp);
        check({tag, ".bus_req_done"}, m_breq, 0);
        check({tag, ".stall_done"}, m_stall, 0);
        step();
        check({tag, ".resp_pulse"}, m_rv, 0);
    endtask

    task automatic misalign(input string tag, input logic [1:0] sz, input logic [63:0] addr);
        issue(1'b0, sz, 1'b0, addr, 64'h0);
        check({tag, ".stall"}, m_stall, 0);
        step();
        req_valid = 1'b0;
        #1;
        check({tag, ".exc"}, m_exc, 1);
        check({tag, ".exc_addr"}, m_ea, addr);
        check({tag, ".bus_req"}, m_breq, 0);
        check({tag, ".stall_after"}, m_stall, 0);
        step();
        check({tag, ".exc_pulse"}, m_exc, 0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
        req_size = 2'd0; req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst.stall", m_stall, 0);
            check("rst.resp_valid", m_rv, 0);
            check("rst.resp_rdata", m_rd, 0);
            check("rst.exc", m_exc, 0);
            check("rst.exc_addr", m_ea, 0);
            check("rst.bus_req", m_breq, 0);
            check("rst.bus_we", m_we, 0);
            check("rst.bus_addr", m_ba, 0);
            check("rst.bus_be", m_be, 0);
            check("rst.bus_wdata", m_bw, 0);
        end
        sel = 1'b0;
        step();

        txn("lw",  1'b0, 2'd2, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF, 1, 64'h100, 64'hF, 64'h0, 64'hDEADBEEF);
        txn("lb",  1'b0, 2'd0, 1'b1, 64'h103, 64'h0, 64'h80123456, 3, 64'h100, 64'h8, 64'h0, 64'hFFFFFF80);
        txn("lbu", 1'b0, 2'd0, 1'b0, 64'h103, 64'h0, 64'h80123456, 3, 64'h100, 64'h8, 64'h0, 64'h80);
        txn("lh",  1'b0, 2'd1, 1'b1, 64'h102, 64'h0, 64'h7FFF0000, 2, 64'h100, 64'hC, 64'h0, 64'h7FFF);
        txn("sh",  1'b1, 2'd1, 1'b0, 64'h202, 64'h0000ABCD, 64'h12345678, 1, 64'h200, 64'hC, 64'hABCD0000, 64'h0);

        misalign("mis_lw", 2'd2, 64'h102);
        misalign("mis_lh", 2'd1, 64'h101);
        misalign("mis_sz3", 2'd3, 64'h100);

        // Reset while busy: the withheld ack arriving later must not produce a response.
        issue(1'b0, 2'd2, 1'b0, 64'h300, 64'h0);
        step();
        req_valid = 1'b0;
        #1;
        check("rstbusy.bus_req_t1", m_breq, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rstbusy.bus_req_t3", m_breq, 0);
        check("rstbusy.resp_t3", m_rv, 0);
        check("rstbusy.stall_t3", m_stall, 0);
        bus_ack = 1'b1;
        bus_rdata = 64'hCAFEF00D;
        step();
        bus_ack = 1'b0;
        #1;
        check("rstbusy.resp_t5", m_rv, 0);
        check("rstbusy.bus_req_t5", m_breq, 0);
        step();
        check("rstbusy.resp_t6", m_rv, 0);

        // Back-to-back loads, second accepted in the first's response cycle.
        issue(1'b0, 2'd2, 1'b0, 64'h400, 64'h0);
        step();
        req_valid = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 64'h11111111;
        #1;
        check("b2b.bus_req_t1", m_breq, 1);
        step();
        bus_ack = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 64'h404, 64'h0);
        check("b2b.resp_t2", m_rv, 1);
        check("b2b.rdata_t2", m_rd, 64'h11111111);
        check("b2b.bus_req_t2", m_breq, 0);
        check("b2b.stall_t2", m_stall, 0);
        step();
        req_valid = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 64'h22222222;
        #1;
        check("b2b.bus_req_t3", m_breq, 1);
        check("b2b.bus_addr_t3", m_ba, 64'h404);
        check("b2b.resp_t3", m_rv, 0);
        step();
        bus_ack = 1'b0;
        #1;
        check("b2b.resp_t4", m_rv, 1);
        check("b2b.rdata_t4", m_rd, 64'h22222222);
        step();

        sel = 1'b1;
        #1;
        txn("ld64", 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF, 1, 64'h8, 64'hFF, 64'h0, 64'h0123456789ABCDEF);
        txn("lw64", 1'b0, 2'd2, 1'b1, 64'hC, 64'h0, 64'h8000000000000000, 2, 64'h8, 64'hF0, 64'h0, 64'hFFFFFFFF80000000);
        txn("sb64", 1'b1, 2'd0, 1'b0, 64'h15, 64'h000000000000005A, 64'h0, 1, 64'h10, 64'h20, 64'h00005A0000000000, 64'h0);
        misalign("mis_ld64", 2'd3, 64'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
